exe_stage: RTL

- Execute stage of the 5-stage in-order pipeline, between ID and MEM.
- Latches one instruction from ID and computes the 32-bit ALU result.
- Runs 32/32 divide/modulo on an iterative radix-2 divider, issuing the data-SRAM request for loads and stores.
- Forwards {res_from_mem, gr_we, dest, result, pc} to MEM and publishes hazard/forwarding info back to ID.

---
 rtl/exe_stage_if.sv | 27 ++
 rtl/exe_stage.sv | 154 +++++++++++++++
 2 files changed

// File: rtl/exe_stage_if.sv
// Execute-stage connection bundle: the ID->EXE and EXE->MEM handshakes, the data-SRAM request
// and the ID hazard feedback.
interface exe_stage_if;
    logic         ms_allowin;
    logic         es_allowin;
    logic         ds_to_es_valid;
    logic [151:0] ds_to_es_bus;
    logic         es_to_ms_valid;
    logic [70:0]  es_to_ms_bus;
    logic         data_sram_en;
    logic [3:0]   data_sram_we;
    logic [31:0]  data_sram_addr;
    logic [31:0]  data_sram_wdata;
    logic [7:0]   es_to_ds_bus;

    modport slave (
        input  ms_allowin, ds_to_es_valid, ds_to_es_bus,
        output es_allowin, es_to_ms_valid, es_to_ms_bus, data_sram_en, data_sram_we,
               data_sram_addr, data_sram_wdata, es_to_ds_bus
    );

    modport master (
        output ms_allowin, ds_to_es_valid, ds_to_es_bus,
        input  es_allowin, es_to_ms_valid, es_to_ms_bus, data_sram_en, data_sram_we,
               data_sram_addr, data_sram_wdata, es_to_ds_bus
    );
endinterface

// File: rtl/exe_stage.sv
// Execute stage: single-cycle ALU, 33-cycle restoring radix-2 divider and word-wide
// data-SRAM request issue; forwards results to MEM and hazard info to ID.
module exe_stage (
    input  logic        clk,
    input  logic        reset,
    exe_stage_if.slave  bus
);

    typedef enum logic [1:0] {StIdle, StCalc, StDone} div_state_e;

    logic         es_valid_q, es_valid_d;
    logic [151:0] ds_bus_q, ds_bus_d;
    div_state_e   div_state_q, div_state_d;
    logic [4:0]   count_q, count_d;
    logic [31:0]  rem_q, rem_d;
    logic [31:0]  quo_q, quo_d;
    logic [31:0]  divisor_q, divisor_d;

    logic [11:0] alu_op;
    logic [3:0]  div_op;
    logic        mem_we, res_from_mem, gr_we;
    logic [4:0]  dest;
    logic [31:0] src1, src2, rkd_value, pc;

    assign {alu_op, div_op, mem_we, res_from_mem, gr_we, dest, src1, src2, rkd_value, pc} =
        ds_bus_q;

    // Handshake
    logic is_div, es_ready_go, es_allowin;
    assign is_div      = |div_op;
    assign es_ready_go = is_div ? (div_state_q == StDone) : 1'b1;
    assign es_allowin  = !es_valid_q || (es_ready_go && bus.ms_allowin);

    always_comb begin
        es_valid_d = es_valid_q;
        ds_bus_d   = ds_bus_q;
        if (es_allowin) begin
            es_valid_d = bus.ds_to_es_valid;
        end
        if (bus.ds_to_es_valid && es_allowin) begin
            ds_bus_d = bus.ds_to_es_bus;
        end
    end

    // ALU
    logic [4:0]  sh_amt;
    logic [31:0] add_res, sub_res, slt_res, sltu_res, alu_result;
    assign sh_amt   = src2[4:0];
    assign add_res  = src1 + src2;
    assign sub_res  = src1 - src2;
    assign slt_res  = {31'b0, $signed(src1) < $signed(src2)};
    assign sltu_res = {31'b0, src1 < src2};

    assign alu_result = ({32{alu_op[0]}}  & add_res)
                      | ({32{alu_op[1]}}  & sub_res)
                      | ({32{alu_op[2]}}  & slt_res)
                      | ({32{alu_op[3]}}  & sltu_res)
                      | ({32{alu_op[4]}}  & (src1 & src2))
                      | ({32{alu_op[5]}}  & ~(src1 | src2))
                      | ({32{alu_op[6]}}  & (src1 | src2))
                      | ({32{alu_op[7]}}  & (src1 ^ src2))
                      | ({32{alu_op[8]}}  & (src1 << sh_amt))
                      | ({32{alu_op[9]}}  & (src1 >> sh_amt))
                      | ({32{alu_op[10]}} & 32'($signed(src1) >>> sh_amt))
                      | ({32{alu_op[11]}} & src2);

    // Divider operands: signed ops work on magnitudes and fix signs afterwards
    logic        signed_op, src1_neg, src2_neg;
    logic [31:0] abs1, abs2;
    assign signed_op = div_op[0] | div_op[1];
    assign src1_neg  = signed_op & src1[31];
    assign src2_neg  = signed_op & src2[31];
    assign abs1      = src1_neg ? -src1 : src1;
    assign abs2      = src2_neg ? -src2 : src2;

    // Partial remainder stays below the divisor, so 33 bits hold the shifted trial exactly
    logic [32:0] shifted, trial;
    assign shifted = {rem_q, quo_q[31]};
    assign trial   = shifted - {1'b0, divisor_q};

    always_comb begin
        div_state_d = div_state_q;
        count_d     = count_q;
        rem_d       = rem_q;
        quo_d       = quo_q;
        divisor_d   = divisor_q;
        unique case (div_state_q)
            StIdle: begin
                if (es_valid_q && is_div) begin
                    rem_d       = '0;
                    quo_d       = abs1;
                    divisor_d   = abs2;
                    count_d     = '0;
                    div_state_d = StCalc;
                end
            end
            StCalc: begin
                rem_d   = trial[32] ? shifted[31:0] : trial[31:0];
                quo_d   = {quo_q[30:0], ~trial[32]};
                count_d = count_q + 5'd1;
                if (count_q == 5'd31) begin
                    div_state_d = StDone;
                end
            end
            StDone: begin
                if (bus.ms_allowin) begin
                    div_state_d = StIdle;
                end
            end
            default: div_state_d = StIdle;
        endcase
    end

    logic        quot_sel, div_by_zero;
    logic [31:0] quo_fix, rem_fix, div_result, es_result;
    assign quot_sel    = div_op[0] | div_op[2];
    assign div_by_zero = (src2 == 32'h0);
    assign quo_fix     = (src1_neg ^ src2_neg) ? -quo_q : quo_q;
    assign rem_fix     = src1_neg ? -rem_q : rem_q;
    assign div_result  = div_by_zero ? (quot_sel ? 32'hFFFF_FFFF : src1)
                                     : (quot_sel ? quo_fix : rem_fix);
    assign es_result   = is_div ? div_result : alu_result;

    always_ff @(posedge clk) begin
        if (!reset) begin
            es_valid_q  <= 1'b0;
            ds_bus_q    <= '0;
            div_state_q <= StIdle;
            count_q     <= '0;
            rem_q       <= '0;
            quo_q       <= '0;
            divisor_q   <= '0;
        end else begin
            es_valid_q  <= es_valid_d;
            ds_bus_q    <= ds_bus_d;
            div_state_q <= div_state_d;
            count_q     <= count_d;
            rem_q       <= rem_d;
            quo_q       <= quo_d;
            divisor_q   <= divisor_d;
        end
    end

    // Memory request only fires on the cycle the instruction moves to MEM
    assign bus.es_allowin      = es_allowin;
    assign bus.es_to_ms_valid  = es_valid_q && es_ready_go;
    assign bus.es_to_ms_bus    = {res_from_mem, gr_we, dest, es_result, pc};
    assign bus.data_sram_en    = es_valid_q && (mem_we || res_from_mem) && bus.ms_allowin;
    assign bus.data_sram_we    = {4{es_valid_q && mem_we && bus.ms_allowin}};
    assign bus.data_sram_addr  = alu_result;
    assign bus.data_sram_wdata = rkd_value;
    assign bus.es_to_ds_bus    = {es_valid_q, gr_we, res_from_mem, dest};

endmodule
